// File: rtl/fifo_rd_packer.sv
// fifo_rd_packer: drains a 1-cycle-latency FIFO read port and packs
// PACK words per wide beat on a valid/ready output, with flush support.
module fifo_rd_packer #(
  parameter int DATA_W = 8,
  parameter int PACK   = 4,
  parameter int CNT_W  = $clog2(PACK + 1)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [DATA_W-1:0]        fifo_rdata,
  input  logic                     fifo_empty,
  output logic                     fifo_rd_en,
  input  logic                     flush,
  output logic [PACK*DATA_W-1:0]   out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [CNT_W-1:0]         out_cnt,
  output logic                     out_last,
  output logic                     flush_done,
  output logic                     busy
);

  typedef enum logic [1:0] {
    RUN,
    FLUSH_WAIT,
    FLUSH_EMIT
  } state_t;

  localparam logic [CNT_W-1:0] PACK_C = CNT_W'(PACK);
  localparam logic [CNT_W:0]   PACK_X = (CNT_W + 1)'(PACK);

  state_t                  state;
  state_t                  state_nx;
  logic [CNT_W-1:0]        cnt;
  logic                    inflight;
  logic [DATA_W-1:0]       lanes [PACK];
  logic [CNT_W:0]          fill;
  logic                    out_free;
  logic                    hs;
  logic                    full_xfer;
  logic                    part_xfer;
  logic [PACK*DATA_W-1:0]  pack_data;

  assign fill      = {1'b0, cnt} + {{CNT_W{1'b0}}, inflight};
  assign out_free  = !out_valid || out_ready;
  assign hs        = out_valid && out_ready;
  assign full_xfer = (cnt == PACK_C) && out_free;

  // Gated by rst so the strobe is low while reset is held.
  assign fifo_rd_en = rst && !fifo_empty && (state == RUN)
                   && !flush && (fill < PACK_X);

  assign busy = (state != RUN) || (cnt != '0)
             || inflight || out_valid;

  always_comb begin
    pack_data = '0;
    for (int k = 0; k < PACK; k++) begin
      if (CNT_W'(k) < cnt) begin
        pack_data[k*DATA_W +: DATA_W] = lanes[k];
      end
    end
  end

  always_comb begin
    state_nx   = state;
    flush_done = 1'b0;
    part_xfer  = 1'b0;
    unique case (state)
      RUN: begin
        if (flush) state_nx = FLUSH_WAIT;
      end
      FLUSH_WAIT: begin
        if (!inflight && (cnt != PACK_C)) begin
          if (cnt != '0) begin
            state_nx = FLUSH_EMIT;
          end else begin
            flush_done = 1'b1;
            state_nx   = RUN;
          end
        end
      end
      FLUSH_EMIT: begin
        // cnt==0 here means the partial beat is already loaded.
        if (cnt != '0) begin
          part_xfer = out_free;
        end else if (hs) begin
          flush_done = 1'b1;
          state_nx   = RUN;
        end
      end
      default: state_nx = RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= RUN;
      cnt      <= '0;
      inflight <= 1'b0;
      for (int k = 0; k < PACK; k++) begin
        lanes[k] <= '0;
      end
    end else begin
      state    <= state_nx;
      inflight <= fifo_rd_en;
      if (full_xfer || part_xfer) begin
        cnt <= '0;
      end else if (inflight) begin
        for (int k = 0; k < PACK; k++) begin
          if (cnt == CNT_W'(k)) lanes[k] <= fifo_rdata;
        end
        cnt <= cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_data  <= '0;
      out_valid <= 1'b0;
      out_cnt   <= '0;
      out_last  <= 1'b0;
    end else if (full_xfer || part_xfer) begin
      out_data  <= pack_data;
      out_valid <= 1'b1;
      out_cnt   <= cnt;
      out_last  <= part_xfer;
    end else if (hs) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fifo_rd_packer.sv
// tb_fifo_rd_packer: table vectors, directed corner sequences and a
// randomized run against a word-grouping reference model.
module tb_fifo_rd_packer;

  localparam int DW = 8;
  localparam int PK = 4;
  localparam int CW = $clog2(PK + 1);

  logic             clk = 1'b0;
  logic             rst;
  logic [DW-1:0]    fifo_rdata;
  logic             fifo_empty;
  logic             fifo_rd_en;
  logic             flush;
  logic [PK*DW-1:0] out_data;
  logic             out_valid;
  logic             out_ready;
  logic [CW-1:0]    out_cnt;
  logic             out_last;
  logic             flush_done;
  logic             busy;

  fifo_rd_packer #(.DATA_W(DW), .PACK(PK)) dut (
    .clk       (clk),
    .rst       (rst),
    .fifo_rdata(fifo_rdata),
    .fifo_empty(fifo_empty),
    .fifo_rd_en(fifo_rd_en),
    .flush     (flush),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_cnt   (out_cnt),
    .out_last  (out_last),
    .flush_done(flush_done),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int rd_cnt = 0;
  int fd_cnt = 0;
  bit hold_empty = 1'b0;

  logic [DW-1:0]    fq [$];
  logic [PK*DW-1:0] got_d [$];
  int               got_c [$];
  bit               got_l [$];
  logic [PK*DW-1:0] exp_d [$];
  int               exp_c [$];
  bit               exp_l [$];

  bit               stall_v = 1'b0;
  logic [PK*DW-1:0] stall_d;
  logic [CW-1:0]    stall_c;
  logic             stall_l;

  typedef struct {
    int          n;
    logic [63:0] w;
    bit          fl;
    int          nb;
    logic [31:0] d0;
    int          c0;
    bit          l0;
    logic [31:0] d1;
    int          c1;
    bit          l1;
  } vec_t;

  vec_t vt [6];

  task automatic chk(string name, logic [63:0] got, logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic upd_empty();
    fifo_empty = (fq.size() == 0) || hold_empty;
  endtask

  task automatic push(logic [DW-1:0] w);
    fq.push_back(w);
    upd_empty();
  endtask

  task automatic clear_obs();
    got_d.delete(); got_c.delete(); got_l.delete();
    exp_d.delete(); exp_c.delete(); exp_l.delete();
    fd_cnt = 0;
    rd_cnt = 0;
  endtask

  task automatic add_exp(logic [31:0] d, int c, bit l);
    exp_d.push_back(d);
    exp_c.push_back(c);
    exp_l.push_back(l);
  endtask

  // One clock: observe before the edge, emulate the FIFO after it.
  task automatic step();
    bit rd;
    @(negedge clk);
    rd = fifo_rd_en;
    if (rd) begin
      chk("rd_while_empty", 64'(fifo_empty), 64'd0);
      rd_cnt++;
    end
    if (stall_v) begin
      chk("stall_valid", 64'(out_valid), 64'd1);
      chk("stall_data", 64'(out_data), 64'(stall_d));
      chk("stall_cnt_last", {out_cnt, out_last}, {stall_c, stall_l});
    end
    stall_v = out_valid && !out_ready;
    stall_d = out_data;
    stall_c = out_cnt;
    stall_l = out_last;
    if (out_valid && out_ready) begin
      got_d.push_back(out_data);
      got_c.push_back(int'(out_cnt));
      got_l.push_back(out_last);
    end
    if (flush_done) fd_cnt++;
    @(posedge clk);
    #1;
    flush = 1'b0;
    if (rd && fq.size() > 0) fifo_rdata = fq.pop_front();
    upd_empty();
  endtask

  task automatic steps(int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic cmp_beats(string tag);
    chk({tag, "_nbeats"}, 64'(got_d.size()), 64'(exp_d.size()));
    for (int i = 0; i < exp_d.size() && i < got_d.size(); i++) begin
      chk({tag, "_data"}, 64'(got_d[i]), 64'(exp_d[i]));
      chk({tag, "_cnt"}, 64'(got_c[i]), 64'(exp_c[i]));
      chk({tag, "_last"}, 64'(got_l[i]), 64'(exp_l[i]));
    end
  endtask

  // Reference: words group into beats of PK in arrival order; a flush
  // turns the leftover tail into one short beat marked last.
  task automatic model_words(logic [DW-1:0] w [$], bit fl);
    int n = w.size();
    for (int b = 0; b * PK < n; b++) begin
      logic [31:0] d = '0;
      int c = 0;
      for (int k = 0; k < PK && b * PK + k < n; k++) begin
        d[k*DW +: DW] = w[b*PK + k];
        c++;
      end
      if (c == PK || fl) add_exp(d, c, c < PK);
    end
  endtask

  task automatic drain(int budget);
    int t = 0;
    while (fq.size() != 0 && t < budget) begin
      step();
      t++;
    end
    chk("drain_timeout", 64'(fq.size()), 64'd0);
  endtask

  task automatic chk_all_zero(string tag);
    chk({tag, "_valid"}, 64'(out_valid), 64'd0);
    chk({tag, "_data"}, 64'(out_data), 64'd0);
    chk({tag, "_cnt"}, 64'(out_cnt), 64'd0);
    chk({tag, "_last_fd_busy_rd"},
        {out_last, flush_done, busy, fifo_rd_en}, 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DW-1:0] rw [$];
    int pushed;
    int t;

    vt[0] = '{4, 64'h44332211, 1'b0, 1,
              32'h44332211, 4, 1'b0, 32'h0, 0, 1'b0};
    vt[1] = '{3, 64'hA3A2A1, 1'b1, 1,
              32'h00A3A2A1, 3, 1'b1, 32'h0, 0, 1'b0};
    vt[2] = '{0, 64'h0, 1'b1, 0,
              32'h0, 0, 1'b0, 32'h0, 0, 1'b0};
    vt[3] = '{6, 64'h060504030201, 1'b1, 2,
              32'h04030201, 4, 1'b0, 32'h00000605, 2, 1'b1};
    vt[4] = '{8, 64'h0807060504030201, 1'b1, 2,
              32'h04030201, 4, 1'b0, 32'h08070605, 4, 1'b0};
    vt[5] = '{5, 64'h1413121110, 1'b1, 2,
              32'h13121110, 4, 1'b0, 32'h00000014, 1, 1'b1};

    rst = 1'b0;
    flush = 1'b0;
    out_ready = 1'b0;
    fifo_rdata = '0;
    upd_empty();
    #2;
    chk_all_zero("reset");
    steps(2);
    rst = 1'b1;
    steps(1);
    chk_all_zero("idle");

    for (int v = 0; v < 6; v++) begin
      clear_obs();
      out_ready = 1'b1;
      for (int j = 0; j < vt[v].n; j++) push(vt[v].w[j*8 +: 8]);
      drain(40);
      if (vt[v].fl) begin
        flush = 1'b1;
      end
      steps(25);
      if (vt[v].nb > 0) add_exp(vt[v].d0, vt[v].c0, vt[v].l0);
      if (vt[v].nb > 1) add_exp(vt[v].d1, vt[v].c1, vt[v].l1);
      cmp_beats($sformatf("vec%0d", v));
      chk($sformatf("vec%0d_fdone", v), 64'(fd_cnt), 64'(vt[v].fl));
      chk($sformatf("vec%0d_busy", v), 64'(busy), 64'd0);
    end

    // Back-pressure: pack and output register fill, then reads stop.
    clear_obs();
    out_ready = 1'b0;
    for (int j = 1; j <= 12; j++) push(8'(j));
    steps(20);
    chk("bp_reads", 64'(rd_cnt), 64'd8);
    chk("bp_left", 64'(fq.size()), 64'd4);
    chk("bp_valid", 64'(out_valid), 64'd1);
    out_ready = 1'b1;
    steps(30);
    add_exp(32'h04030201, 4, 1'b0);
    add_exp(32'h08070605, 4, 1'b0);
    add_exp(32'h0C0B0A09, 4, 1'b0);
    cmp_beats("bp");

    // Flush with nothing buffered.
    clear_obs();
    steps(2);
    flush = 1'b1;
    step();
    chk("fidle_done", 64'(flush_done), 64'd1);
    step();
    chk("fidle_done_drop", 64'(flush_done), 64'd0);
    chk("fidle_busy", 64'(busy), 64'd0);
    cmp_beats("fidle");

    // Flush while the 4th word is in flight.
    clear_obs();
    out_ready = 1'b1;
    for (int j = 0; j < 4; j++) push(8'h31 + 8'(j));
    t = 0;
    while (rd_cnt < 4 && t < 20) begin
      step();
      t++;
    end
    chk("fin_reads", 64'(rd_cnt), 64'd4);
    flush = 1'b1;
    steps(20);
    add_exp(32'h34333231, 4, 1'b0);
    cmp_beats("fin");
    chk("fin_fdone", 64'(fd_cnt), 64'd1);
    chk("fin_busy", 64'(busy), 64'd0);

    // Asynchronous reset mid-pack.
    clear_obs();
    out_ready = 1'b0;
    for (int j = 0; j < 4; j++) push(8'h51 + 8'(j));
    t = 0;
    while (!out_valid && t < 20) begin
      step();
      t++;
    end
    push(8'h61);
    push(8'h62);
    steps(4);
    chk("pre_rst_valid", 64'(out_valid), 64'd1);
    chk("pre_rst_busy", 64'(busy), 64'd1);
    push(8'h63);
    #2;
    rst = 1'b0;
    #1;
    chk_all_zero("async_rst");
    fq.delete();
    upd_empty();
    fifo_rdata = '0;
    stall_v = 1'b0;
    steps(2);
    rst = 1'b1;
    clear_obs();
    out_ready = 1'b1;
    for (int j = 0; j < 4; j++) push(8'hC1 + 8'(j));
    steps(15);
    add_exp(32'hC4C3C2C1, 4, 1'b0);
    cmp_beats("post_rst");

    // Randomized stream with stalls and empty-flag toggling.
    clear_obs();
    rw.delete();
    pushed = 0;
    t = 0;
    while ((pushed < 41 || fq.size() != 0) && t < 3000) begin
      if (pushed < 41 && $urandom_range(0, 2) != 0) begin
        logic [DW-1:0] w = 8'($urandom);
        rw.push_back(w);
        push(w);
        pushed++;
      end
      out_ready = ($urandom_range(0, 3) != 0);
      hold_empty = ($urandom_range(0, 7) == 0);
      upd_empty();
      step();
      t++;
    end
    hold_empty = 1'b0;
    upd_empty();
    chk("rand_feed", 64'(pushed + fq.size()), 64'd41);
    flush = 1'b1;
    step();
    t = 0;
    while ((fd_cnt == 0 || busy) && t < 300) begin
      out_ready = ($urandom_range(0, 2) != 0);
      step();
      t++;
    end
    chk("rand_done_timeout", 64'(t < 300), 64'd1);
    model_words(rw, 1'b1);
    cmp_beats("rand");
    chk("rand_fdone", 64'(fd_cnt), 64'd1);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
